// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the multi-cycle data-memory responder.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RESP
  } state_t;

  localparam int unsigned WORD_BYTES = 4;

  // Countdown holds at most LATENCY-1; a one-bit counter is kept when LATENCY=1.
  function automatic int unsigned cnt_width(input int unsigned latency);
    return (latency <= 1) ? 1 : $clog2(latency);
  endfunction

  function automatic bit latency_ok(input int unsigned latency);
    return latency >= 1;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word array: synchronous write, registered read, no reset.
module dmem_array #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned AW          = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
    if (re) rdata <= mem[idx];
  end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage target with fixed access latency: stalls the pipeline, then acks
// for one cycle with read data or an error flag.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        stall_o,
  output logic        ack_o,
  output logic        err_o
);

  localparam int unsigned AW  = $clog2(DEPTH_WORDS);
  localparam int unsigned OFS = $clog2(WORD_BYTES);
  localparam int unsigned CW  = cnt_width(LATENCY);
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  if (!latency_ok(LATENCY)) begin : g_bad_latency
    $error("dmem_responder: LATENCY must be at least 1");
  end
  if (DEPTH_WORDS < 2 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
    $error("dmem_responder: DEPTH_WORDS must be a power of two >= 2");
  end

  state_t        state;
  logic [CW-1:0] cnt;
  logic          rd_q, wr_q, err_q, rvalid;
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q, rdata;

  logic          req, req_err, accept, finish;
  logic          op_rd, op_wr, op_err, we, re;
  logic [AW-1:0] op_idx;
  logic [31:0]   op_wdata;

  assign req     = MemRead_i | MemWrite_i;
  assign req_err = (MemRead_i & MemWrite_i)
                 | (addr_i[OFS-1:0] != '0)
                 | ({{OFS{1'b0}}, addr_i[31:OFS]} >= 32'(DEPTH_WORDS));

  // Gating with rst_i keeps the array untouched and stall low while in reset.
  assign accept = rst_i && (state == ST_IDLE) && req;
  assign finish = (accept && (LATENCY == 1)) || ((state == ST_BUSY) && (cnt == CW'(1)));

  // With LATENCY=1 the access completes at the capture edge, so use live inputs.
  assign op_rd    = accept ? MemRead_i  : rd_q;
  assign op_wr    = accept ? MemWrite_i : wr_q;
  assign op_err   = accept ? req_err    : err_q;
  assign op_idx   = accept ? addr_i[AW+OFS-1:OFS] : idx_q;
  assign op_wdata = accept ? data_i     : wdata_q;

  assign we = finish & op_wr & ~op_err;
  assign re = finish & op_rd & ~op_err;

  assign stall_o = accept || (state == ST_BUSY);
  assign data_o  = rvalid ? rdata : '0;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk   (clk_i),
    .we    (we),
    .re    (re),
    .idx   (op_idx),
    .wdata (op_wdata),
    .rdata (rdata)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rvalid  <= 1'b0;
      ack_o   <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      ack_o <= finish;
      err_o <= finish & op_err;
      if (re) rvalid <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (req) begin
            rd_q    <= MemRead_i;
            wr_q    <= MemWrite_i;
            err_q   <= req_err;
            idx_q   <= addr_i[AW+OFS-1:OFS];
            wdata_q <= data_i;
            cnt     <= CNT_LOAD;
            state   <= (LATENCY == 1) ? ST_RESP : ST_BUSY;
          end
        end
        ST_BUSY: begin
          cnt <= cnt - CW'(1);
          if (finish) state <= ST_RESP;
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: LATENCY=4 instance (index 0) and LATENCY=1 instance (index 1).
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rd    [2];
  logic        wr    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] dout  [2];
  logic        stall [2];
  logic        ack   [2];
  logic        err   [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .MemRead_i(rd[0]), .MemWrite_i(wr[0]),
    .addr_i(addr[0]), .data_i(wdata[0]), .data_o(dout[0]),
    .stall_o(stall[0]), .ack_o(ack[0]), .err_o(err[0])
  );

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .MemRead_i(rd[1]), .MemWrite_i(wr[1]),
    .addr_i(addr[1]), .data_i(wdata[1]), .data_o(dout[1]),
    .stall_o(stall[1]), .ack_o(ack[1]), .err_o(err[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one request from just after an edge; checks every stall cycle and the ack cycle.
  task automatic access(input int d, input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] dat, input logic eerr, input logic [31:0] edata,
                        input string tag);
    int lat;
    lat = (d == 0) ? 4 : 1;
    rd[d] = r; wr[d] = w; addr[d] = a; wdata[d] = dat;
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      check({tag, "_stall"}, 32'(stall[d]), 32'd1);
      check({tag, "_noack"}, 32'(ack[d]), 32'd0);
      tick();
    end
    @(negedge clk);
    check({tag, "_respstall"}, 32'(stall[d]), 32'd0);
    check({tag, "_ack"}, 32'(ack[d]), 32'd1);
    check({tag, "_err"}, 32'(err[d]), 32'(eerr));
    check({tag, "_data"}, dout[d], edata);
    tick();
    rd[d] = 1'b0; wr[d] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
    end
    rst = 1'b0;
    tick();
    tick();
    check("rst_data", dout[0], 32'h0);
    check("rst_stall", 32'(stall[0]), 32'd0);
    check("rst_ack", 32'(ack[0]), 32'd0);
    check("rst_err", 32'(err[0]), 32'd0);
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("idle_stall", 32'(stall[0]), 32'd0);
    check("idle_ack", 32'(ack[0]), 32'd0);
    tick();

    // Write then read with one idle cycle between, read acks on cycle 10
    access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, "w10");
    tick();
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, "r10");

    // Back-to-back read then write; data_o holds through the write ack
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, "b2b_r10");
    access(0, 1'b0, 1'b1, 32'h14, 32'h12345678, 1'b0, 32'hDEADBEEF, "b2b_w14");
    access(0, 1'b1, 1'b0, 32'h14, 32'h0, 1'b0, 32'h12345678, "r14");

    // Illegal accesses: misaligned, out of range (aliases word 0), read+write
    access(0, 1'b0, 1'b1, 32'h0, 32'h11111111, 1'b0, 32'h12345678, "w0");
    access(0, 1'b1, 1'b0, 32'h13, 32'h0, 1'b1, 32'h12345678, "misalign");
    access(0, 1'b0, 1'b1, 32'h400, 32'h99999999, 1'b1, 32'h12345678, "range");
    access(0, 1'b1, 1'b1, 32'h14, 32'hFFFFFFFF, 1'b1, 32'h12345678, "rdwr");
    access(0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h11111111, "r0_after_err");
    access(0, 1'b1, 1'b0, 32'h14, 32'h0, 1'b0, 32'h12345678, "r14_after_err");

    // Reset during the second BUSY cycle of a write abandons it
    access(0, 1'b0, 1'b1, 32'h20, 32'h55555555, 1'b0, 32'h12345678, "w20");
    rd[0] = 1'b0; wr[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'hAAAAAAAA;
    tick();
    tick();
    check("mid_busy_stall", 32'(stall[0]), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_data", dout[0], 32'h0);
    check("async_rst_stall", 32'(stall[0]), 32'd0);
    check("async_rst_ack", 32'(ack[0]), 32'd0);
    check("async_rst_err", 32'(err[0]), 32'd0);
    wr[0] = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    access(0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 32'h55555555, "r20_after_rst");

    // LATENCY=1 instance
    access(1, 1'b0, 1'b1, 32'h0, 32'hCAFEF00D, 1'b0, 32'h0, "l1_w0");
    access(1, 1'b0, 1'b1, 32'h4, 32'h0BADC0DE, 1'b0, 32'h0, "l1_w4");
    access(1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'hCAFEF00D, "l1_r0");
    access(1, 1'b1, 1'b0, 32'h4, 32'h0, 1'b0, 32'h0BADC0DE, "l1_r4");
    @(negedge clk);
    check("l1_idle_ack", 32'(ack[1]), 32'd0);
    check("l1_idle_stall", 32'(stall[1]), 32'd0);
    check("l1_hold_data", dout[1], 32'h0BADC0DE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
